part_fifo16x4: RTL and testbench

- Single-clock, first-word-fall-through 16x4 buffer that loads nibble words and presents them on a Q bus.
- Sits directly upstream of the 4-bit quad register/driver stage; Q[3:0] drives that stage's I0..I3.
- Fully synchronous replacement for a shift-in/shift-out FIFO part.
- Decouples the producer's nibble stream from the register's clock-enable timing.

---
 rtl/part_fifo16x4.sv | 91 +++++++++
 tb/tb_part_fifo16x4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/part_fifo16x4.sv
// Single-clock first-word-fall-through nibble FIFO (16x4) feeding a quad register stage.
// Define FIFO_HALF_FLAG_EN to add the registered HALF (COUNT >= DEPTH/2) output.
module part_fifo16x4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             SHIFT_IN,
  input  logic             SHIFT_OUT,
  output logic [WIDTH-1:0] Q,
  output logic             IR,
  output logic             OR,
`ifdef FIFO_HALF_FLAG_EN
  output logic             HALF,
`endif
  output logic [AW:0]      COUNT
);

  localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne    = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             ir_q, or_q;
  logic             push, pop;

  // Requests are gated by the registered (pre-edge) flags.
  always_comb begin
    push    = SHIFT_IN && ir_q;
    pop     = SHIFT_OUT && or_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ir_q    <= 1'b1;
      or_q    <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
      count_q <= count_d;
      ir_q    <= (count_d != FullCount);
      or_q    <= (count_d != '0);
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      mem[wptr_q] <= D;
    end
  end

`ifdef FIFO_HALF_FLAG_EN
  localparam logic [AW:0] HalfCount = (AW + 1)'(DEPTH / 2);
  logic half_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      half_q <= 1'b0;
    end else begin
      half_q <= (count_d >= HalfCount);
    end
  end

  assign HALF = half_q;
`endif

  assign Q     = or_q ? mem[rptr_q] : '0;
  assign IR    = ir_q;
  assign OR    = or_q;
  assign COUNT = count_q;

endmodule

// File: tb/tb_part_fifo16x4.sv
// Scoreboard bench for part_fifo16x4: a queue model tracks contents; a monitor checks Q on pops.
module tb_part_fifo16x4;

  localparam int Depth = 16;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       si;
  logic       so;
  logic [3:0] q;
  logic       ir;
  logic       orr;
  logic [4:0] count;
`ifdef FIFO_HALF_FLAG_EN
  logic       half;
`endif

  part_fifo16x4 dut (
    .CLK      (clk),
    .RESET    (rst),
    .D        (d),
    .SHIFT_IN (si),
    .SHIFT_OUT(so),
    .Q        (q),
    .IR       (ir),
    .OR       (orr),
`ifdef FIFO_HALF_FLAG_EN
    .HALF     (half),
`endif
    .COUNT    (count)
  );

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  int         model_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: inputs are stable mid-cycle; a pop that will be accepted must show the model head.
  always @(negedge clk) begin
    if (!rst && so && orr) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_empty_model: DUT offers Q=%0h, model holds no data", q);
      end else begin
        check("pop_data", int'(q), int'(exp_q.pop_front()));
      end
    end
  end

  // Apply one cycle of inputs, advance the model, then check flags after the edge.
  task automatic cyc(input logic r, input logic push, input logic popr, input logic [3:0] din);
    bit push_ok, pop_ok;
    rst = r;
    si  = push;
    so  = popr;
    d   = din;
    if (r) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      push_ok = push && (model_cnt < Depth);
      pop_ok  = popr && (model_cnt > 0);
      if (push_ok) exp_q.push_back(din);
      model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
    end
    @(posedge clk);
    #1;
    check("count", int'(count), model_cnt);
    check("ir", int'(ir), int'(model_cnt != Depth));
    check("or", int'(orr), int'(model_cnt != 0));
    if (model_cnt == 0) check("q_empty_zero", int'(q), 0);
`ifdef FIFO_HALF_FLAG_EN
    check("half", int'(half), int'(model_cnt >= Depth / 2));
`endif
  endtask

  initial begin
    rst = 1'b0;
    si  = 1'b0;
    so  = 1'b0;
    d   = 4'h0;

    // Reset then idle
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);

    // Single word in and out
    cyc(1'b0, 1'b1, 1'b0, 4'hA);
    check("single_q", int'(q), 'hA);
    cyc(1'b0, 1'b0, 1'b1, 4'h0);

    // Fill to full, then a dropped 17th push
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 4'(i));
    cyc(1'b0, 1'b1, 1'b0, 4'h5);
    check("full_head", int'(q), 0);

    // Full plus simultaneous push/pop: pop accepted, push of 7 refused
    cyc(1'b0, 1'b1, 1'b1, 4'h7);
    check("after_full_pp_q", int'(q), 1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 4'h0);

    // Empty plus simultaneous push/pop: push only
    cyc(1'b0, 1'b1, 1'b1, 4'h3);
    check("empty_pp_q", int'(q), 3);
    cyc(1'b0, 1'b0, 1'b1, 4'h0);

    // Wrap-around streaming at COUNT=3
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 4'(i));
    for (int i = 3; i < 43; i++) cyc(1'b0, 1'b1, 1'b1, 4'(i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'h0);

    // COUNT=1 push/pop: new word must fall through, not stale data
    cyc(1'b0, 1'b1, 1'b0, 4'h9);
    cyc(1'b0, 1'b1, 1'b1, 4'h6);
    check("cnt1_pp_q", int'(q), 6);
    cyc(1'b0, 1'b0, 1'b1, 4'h0);

    // Reset mid-stream at COUNT=9 with SHIFT_IN asserted
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 4'(i + 4));
    cyc(1'b1, 1'b1, 1'b0, 4'hE);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);

    // Randomized traffic, push-heavy then pop-heavy, occasional reset
    for (int i = 0; i < 600; i++) begin
      int pin, pout;
      pin  = (i % 200 < 100) ? 75 : 35;
      pout = (i % 200 < 100) ? 35 : 75;
      cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < pin) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < pout) ? 1'b1 : 1'b0,
          4'($urandom));
    end

    // Drain what remains so every stored word is compared
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
